// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 codes, request legality check.
// Pure declarations; no latency or flow control of its own.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // 1 when the request must be rejected: unknown funct3 for its direction, or misaligned
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane selection with sign/zero extension for loads, byte-lane merge for sub-word stores.
// Purely combinational, zero latency; no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    always_comb begin
        w_shifted = i_mem_rd >> {i_addr_lo, 3'b000};
        w_byte    = w_shifted[7:0];
        w_half    = i_addr_lo[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        w_sext    = ~i_funct3[2];

        case (i_funct3[1:0])
            2'b00:   o_load_data = {{24{w_sext & w_byte[7]}}, w_byte};
            2'b01:   o_load_data = {{16{w_sext & w_half[15]}}, w_half};
            default: o_load_data = i_mem_rd;
        endcase

        // Lanes not addressed by the store keep the word just read from memory
        o_store_word = i_mem_rd;
        case (i_funct3[1:0])
            2'b00:   o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            2'b01: begin
                if (i_addr_lo[1])
                    o_store_word[31:16] = i_wdata[15:0];
                else
                    o_store_word[15:0]  = i_wdata[15:0];
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store requester for a word-wide synchronous-read data memory.
// Response 3 cycles after accept (loads/SB/SH), 2 (SW), 1 (error); req_ready only while idle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [N+1:0]  req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_WE,
    output logic [N-1:0]  mem_A,
    output logic [31:0]   mem_WD,
    input  logic [31:0]   mem_RD
);

    lsu_state_t     r_state;
    logic           r_we;
    logic [2:0]     r_funct3;
    logic [N+1:0]   r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_err;

    logic [31:0]    w_load_data;
    logic [31:0]    w_store_word;
    logic           w_is_sw;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_mem_rd     (mem_RD),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    assign w_is_sw = r_we && (r_funct3 == F3_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= 32'd0;
                        if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ACCESS;
                        end
                    end
                end
                // Full-word stores need no read, so they skip the read-back cycle
                ACCESS:  r_state <= w_is_sw ? RESP : WAIT;
                WAIT: begin
                    if (!r_we)
                        r_rdata <= w_load_data;
                    r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE) && !rst;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_A      = r_addr[N+1:2];

    // Write strobe is gated by rst so an aborted read-modify-write never reaches memory
    always_comb begin
        mem_WE = 1'b0;
        mem_WD = 32'd0;
        if (r_state == ACCESS && w_is_sw) begin
            mem_WE = !rst;
            mem_WD = r_wdata;
        end else if (r_state == WAIT && r_we) begin
            mem_WE = !rst;
            mem_WD = w_store_word;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a synchronous-read memory model (N=8).
module tb_load_store_unit;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [N+1:0]  req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_WE;
    logic [N-1:0]  mem_A;
    logic [31:0]   mem_WD;
    logic [31:0]   mem_RD;

    logic          pre_en;
    logic [N-1:0]  pre_a;
    logic [31:0]   pre_d;
    logic [31:0]   mem [0:(1<<N)-1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    always @(posedge clk) begin
        mem_RD <= mem[mem_A];
        if (pre_en)
            mem[pre_a] <= pre_d;
        else if (mem_WE)
            mem[mem_A] <= mem_WD;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          weoff;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t tv[$];
    exp_t sbq[$];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [9:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic err, int lat, int weoff);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.weoff = weoff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request at the current negedge and follows it to its response
    task automatic do_req(input string tag, input vec_t v);
        exp_t e;
        int   lat;
        int   we_n;
        int   we_off;
        bit   done;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.rdata;
        e.err   = v.err;
        sbq.push_back(e);
        lat = 0; we_n = 0; we_off = 0; done = 0;
        for (int c = 1; c <= 10 && !done; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_addr   = 10'($urandom);
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom);
            if (mem_WE) begin
                we_n++;
                we_off = c;
            end
            if (resp_valid) begin
                lat  = c;
                done = 1;
            end
        end
        e = sbq.pop_front();
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no resp_valid within 10 cycles", tag);
        end else begin
            chk({tag, " rdata"}, resp_rdata, e.rdata);
            chk({tag, " err"}, {31'd0, resp_err}, {31'd0, e.err});
            chk({tag, " latency"}, lat, v.lat);
        end
        chk({tag, " we_cycle"}, we_off, v.weoff);
        chk({tag, " we_count"}, we_n, (v.weoff != 0) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        int   issued;
        int   last;
        exp_t e;
        vec_t b2b[$];

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = 32'd0;
        pre_en = 1'b0; pre_a = '0; pre_d = 32'd0;

        @(negedge clk); pre_en = 1'b1; pre_a = 8'h10; pre_d = 32'h8899AABB;
        @(negedge clk); pre_a = 8'h20; pre_d = 32'h11223344;
        @(negedge clk); pre_a = 8'hFF; pre_d = 32'h80123456;
        @(negedge clk); pre_en = 1'b0; rst = 1'b0;
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset mem_WE", {31'd0, mem_WE}, 32'd0);
        chk("reset mem_A", {24'd0, mem_A}, 32'd0);
        chk("reset mem_WD", mem_WD, 32'd0);

        //            we    f3      addr    wdata         rdata         err lat weoff
        tv.push_back(mk(0, 3'b000, 10'h041, 32'h0,        32'hFFFFFFAA, 0, 3, 0));
        tv.push_back(mk(0, 3'b100, 10'h041, 32'h0,        32'h000000AA, 0, 3, 0));
        tv.push_back(mk(0, 3'b001, 10'h042, 32'h0,        32'hFFFF8899, 0, 3, 0));
        tv.push_back(mk(0, 3'b101, 10'h040, 32'h0,        32'h0000AABB, 0, 3, 0));
        tv.push_back(mk(0, 3'b010, 10'h040, 32'h0,        32'h8899AABB, 0, 3, 0));
        tv.push_back(mk(0, 3'b101, 10'h042, 32'h0,        32'h00008899, 0, 3, 0));
        tv.push_back(mk(0, 3'b100, 10'h043, 32'h0,        32'h00000088, 0, 3, 0));
        tv.push_back(mk(1, 3'b000, 10'h042, 32'h123456CC, 32'h0,        0, 3, 2));
        tv.push_back(mk(0, 3'b010, 10'h040, 32'h0,        32'h88CCAABB, 0, 3, 0));
        tv.push_back(mk(1, 3'b010, 10'h040, 32'hDEADBEEF, 32'h0,        0, 2, 1));
        tv.push_back(mk(1, 3'b001, 10'h040, 32'hABCD1234, 32'h0,        0, 3, 2));
        tv.push_back(mk(0, 3'b010, 10'h040, 32'h0,        32'hDEAD1234, 0, 3, 0));
        tv.push_back(mk(0, 3'b010, 10'h042, 32'h0,        32'h0,        1, 1, 0));
        tv.push_back(mk(0, 3'b011, 10'h040, 32'h0,        32'h0,        1, 1, 0));
        tv.push_back(mk(0, 3'b001, 10'h041, 32'h0,        32'h0,        1, 1, 0));
        tv.push_back(mk(1, 3'b011, 10'h040, 32'h5A5A5A5A, 32'h0,        1, 1, 0));
        tv.push_back(mk(0, 3'b110, 10'h040, 32'h0,        32'h0,        1, 1, 0));
        tv.push_back(mk(1, 3'b001, 10'h043, 32'h00007777, 32'h0,        1, 1, 0));
        tv.push_back(mk(0, 3'b000, 10'h3FF, 32'h0,        32'hFFFFFF80, 0, 3, 0));
        tv.push_back(mk(0, 3'b101, 10'h3FE, 32'h0,        32'h00008012, 0, 3, 0));
        tv.push_back(mk(1, 3'b001, 10'h082, 32'h5555AAAA, 32'h0,        0, 3, 2));
        tv.push_back(mk(0, 3'b010, 10'h080, 32'h0,        32'hAAAA3344, 0, 3, 0));

        foreach (tv[i]) do_req($sformatf("vec%0d", i), tv[i]);

        // Reset lands in the read-back cycle of an SB: the merge must never be written
        chk("rmw ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 10'h081; req_wdata = 32'h000000EE;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw access no write", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        chk("rmw wait write pending", {31'd0, mem_WE}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw rst gates write", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmw ready after rst", {31'd0, req_ready}, 32'd1);
        chk("rmw rdata cleared", resp_rdata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rmw no resp c%0d", c), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("rmw no we c%0d", c), {31'd0, mem_WE}, 32'd0);
            @(negedge clk);
        end
        do_req("rmw readback", mk(0, 3'b010, 10'h080, 32'h0, 32'hAAAA3344, 0, 3, 0));

        // req_valid held high across three loads: one response every 4 cycles
        b2b.push_back(mk(0, 3'b010, 10'h040, 32'h0, 32'hDEAD1234, 0, 3, 0));
        b2b.push_back(mk(0, 3'b010, 10'h080, 32'h0, 32'hAAAA3344, 0, 3, 0));
        b2b.push_back(mk(0, 3'b010, 10'h3FC, 32'h0, 32'h80123456, 0, 3, 0));
        got = 0; issued = 0; last = 0;
        req_valid = 1'b1; req_we = 1'b0;
        req_funct3 = b2b[0].f3; req_addr = b2b[0].addr; req_wdata = 32'h0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b2b unexpected response at cycle %0d", c);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("b2b%0d rdata", got), resp_rdata, e.rdata);
                    chk($sformatf("b2b%0d err", got), {31'd0, resp_err}, {31'd0, e.err});
                end
                if (got > 0)
                    chk($sformatf("b2b%0d spacing", got), c - last, 4);
                last = c;
                got++;
            end
            if (req_valid && req_ready) begin
                e.rdata = b2b[issued].rdata;
                e.err   = b2b[issued].err;
                sbq.push_back(e);
                issued++;
            end
            @(negedge clk);
            if (issued < 3) begin
                req_funct3 = b2b[issued].f3;
                req_addr   = b2b[issued].addr;
            end else begin
                req_valid = 1'b0;
            end
        end
        chk("b2b responses", got, 3);
        chk("b2b accepted", issued, 3);
        req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Single-cycle-core-side requester for the word-wide synchronous data memory. Accepts one load or store per request from the core using RISC-V funct3 encoding, translates byte addresses to word addresses, performs byte/halfword extraction with sign/zero extension on loads and read-modify-write merging on sub-word stores, and returns a one-cycle response pulse. Sits between the execute/memory stage control and the data memory instance.

## Interface
- N, 20, word-address width of the data memory (2^N words); data width fixed at 32
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  N+2  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid
- mem_WE  out  1  memory write enable
- mem_A  out  N  memory word address
- mem_WD  out  32  memory write data
- mem_RD  in  32  memory read data, registered inside memory: reflects mem_A of previous cycle, pre-write contents

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr, wdata. Illegal funct3 (load 011/110/111, store ≥011) or misaligned (half with addr[0]=1, word with addr[1:0]≠0) → set err, go RESP, no memory access. Otherwise → ACCESS.
- ACCESS: mem_A=addr[N+1:2]. SW: mem_WE=1, mem_WD=wdata, → RESP. Loads, SB, SH: mem_WE=0, → WAIT.
- WAIT: mem_RD valid. Load: select lane by addr[1:0] (byte) or addr[1] (half), sign-extend for LB/LH, zero-extend for LBU/LHU, store in resp_rdata register, → RESP. SB/SH: merge wdata into selected lane(s) of mem_RD, mem_WE=1, mem_WD=merged, mem_A unchanged, → RESP.
- RESP: resp_valid=1, resp_rdata/resp_err stable, → IDLE. req_ready=0 here; back-to-back request accepted earliest the cycle after RESP.
- mem_WE is a decode of state + latched op; never high outside ACCESS (SW) or WAIT (SB/SH).
- Byte-lane merge: lane k = addr[1:0] for SB; lanes {2·addr[1], 2·addr[1]+1} for SH; other lanes keep mem_RD.

## Timing
- Accept at cycle t (req_valid & req_ready). resp_valid at: t+3 for loads, SB, SH; t+2 for SW; t+1 for error.
- Memory write occurs at end of t+1 (SW) or t+2 (SB/SH).
- resp_rdata, resp_err registered; hold value until next accept, cleared to 0 at accept.
- Reset values: state IDLE, req_ready 1 (after the reset cycle), resp_valid 0, resp_rdata 0, resp_err 0, mem_WE 0, mem_A 0, mem_WD 0, latched request regs 0.
- Reset mid-operation: next state IDLE, no response, no pending write issued (RMW aborted in WAIT leaves memory unchanged since mem_WE is forced 0 while rst=1).
- req fields ignored when req_ready=0; req_valid held high during busy cycles is accepted in the first IDLE cycle.
- Highest address: addr = 2^(N+2)−1 with LB is legal, mem_A = 2^N−1; no wrap logic needed.

## Structure
- Package lsu_pkg: state enum (IDLE, ACCESS, WAIT, RESP), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), legality/alignment check function.
- Sub-module lsu_align: combinational; inputs funct3, addr[1:0], mem_RD, wdata; outputs extended load value and merged store word. Top holds FSM, request latch, response registers.

## Test plan
- Bench uses a synchronous-read memory model with N=8, preloaded word 0x10 = 0x8899AABB.
- LB addr 0x41 → resp_rdata 0xFFFFFFAA at t+3; LBU 0x41 → 0x000000AA; LH 0x42 → 0xFFFF8899; LHU 0x40 → 0x0000AABB; LW 0x40 → 0x8899AABB.
- SB addr 0x42 wdata 0x123456CC → mem_WE only at t+2, word 0x10 becomes 0x88CCAABB; then LW 0x40 returns 0x88CCAABB.
- SW addr 0x40 wdata 0xDEADBEEF → mem_WE at t+1, resp_valid at t+2; SH addr 0x40 wdata 0x1234 then LW → 0xDEAD1234.
- LW addr 0x42 → resp_valid t+1, resp_err 1, resp_rdata 0, mem_WE never asserted; load funct3 011 → same.
- rst asserted during WAIT of SB → no write, resp_valid stays 0, req_ready 1 the cycle after rst deasserts; req_valid held continuously across three LW requests → responses every 4 cycles, no request lost.
